// File: rtl/ivl_ovl_pkg.sv
// Shared types, default parameters and saturating add for the OVL window checkers.
package ivl_ovl_pkg;

    typedef enum logic {IDLE = 1'b0, WINDOW = 1'b1} win_state_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MAX_WIN = 0;
    localparam int DEF_CNT_W   = 8;

    // Adds two values and clamps to 2^w-1; w may be 1..32.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/ivl_ovl_win_unchange_chan.sv
// One channel of the window-unchange checker: FSM, capture, window counter, fire flops.
// IVL_OVL_WIN_COVER_EN adds a combinational clean-close strobe for the window counter.
module ivl_ovl_win_unchange_chan
    import ivl_ovl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_WIN = DEF_MAX_WIN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_start,
    input  logic             i_end,
    input  logic [WIDTH-1:0] i_expr,
`ifdef IVL_OVL_WIN_COVER_EN
    output logic             o_clean,
`endif
    output logic             o_fire_change,
    output logic             o_fire_timeout,
    output logic             o_active
);

    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_WIN);

    win_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cap, w_cap_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_fire_chg, r_fire_to;
    logic             w_chg, w_to;
`ifdef IVL_OVL_WIN_COVER_EN
    logic             r_viol, w_viol_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cap_nxt   = r_cap;
        w_cnt_nxt   = r_cnt;
        w_chg       = 1'b0;
        w_to        = 1'b0;
`ifdef IVL_OVL_WIN_COVER_EN
        w_viol_nxt  = r_viol;
        o_clean     = 1'b0;
`endif
        if (!i_enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    w_state_nxt = WINDOW;
                    w_cap_nxt   = i_expr;
                    w_cnt_nxt   = '0;
`ifdef IVL_OVL_WIN_COVER_EN
                    w_viol_nxt  = 1'b0;
`endif
                end
                WINDOW: begin
                    // Case inequality so an unknown sample is treated as a change.
                    w_chg     = (i_expr !== r_cap);
                    w_cap_nxt = i_expr;
                    if (i_end) begin
                        w_state_nxt = IDLE;
`ifdef IVL_OVL_WIN_COVER_EN
                        o_clean     = !(r_viol || w_chg);
`endif
                    end else if (MAX_WIN > 0) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (w_cnt_nxt == MAX_L) begin
                            w_to        = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
`ifdef IVL_OVL_WIN_COVER_EN
                    w_viol_nxt = r_viol | w_chg | w_to;
`endif
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cap      <= '0;
            r_cnt      <= '0;
            r_fire_chg <= 1'b0;
            r_fire_to  <= 1'b0;
`ifdef IVL_OVL_WIN_COVER_EN
            r_viol     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cap      <= w_cap_nxt;
            r_cnt      <= w_cnt_nxt;
            r_fire_chg <= w_chg;
            r_fire_to  <= w_to;
`ifdef IVL_OVL_WIN_COVER_EN
            r_viol     <= w_viol_nxt;
`endif
        end
    end

    assign o_fire_change  = r_fire_chg;
    assign o_fire_timeout = r_fire_to;
    assign o_active       = (r_state == WINDOW);

endmodule

// File: rtl/ivl_ovl_win_unchange_multi.sv
// Multi-channel window-unchange checker with shared saturating error counter.
// Define IVL_OVL_WIN_COVER_EN to add the win_count clean-close counter output.
module ivl_ovl_win_unchange_multi
    import ivl_ovl_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_WIN = DEF_MAX_WIN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       start_event,
    input  logic [NUM_CH-1:0]       end_event,
    input  logic [NUM_CH*WIDTH-1:0] test_expr,
    output logic [NUM_CH-1:0]       fire_change,
    output logic [NUM_CH-1:0]       fire_timeout,
    output logic [NUM_CH-1:0]       win_active,
`ifdef IVL_OVL_WIN_COVER_EN
    output logic [CNT_W-1:0]        win_count,
`endif
    output logic [CNT_W-1:0]        err_count
);

    logic [6:0] w_pop;
`ifdef IVL_OVL_WIN_COVER_EN
    logic [NUM_CH-1:0] w_clean;
    logic [6:0]        w_clean_pop;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ivl_ovl_win_unchange_chan #(
            .WIDTH  (WIDTH),
            .MAX_WIN(MAX_WIN),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clock         (clock),
            .reset         (reset),
            .i_enable      (enable),
            .i_start       (start_event[c]),
            .i_end         (end_event[c]),
            .i_expr        (test_expr[c*WIDTH +: WIDTH]),
`ifdef IVL_OVL_WIN_COVER_EN
            .o_clean       (w_clean[c]),
`endif
            .o_fire_change (fire_change[c]),
            .o_fire_timeout(fire_timeout[c]),
            .o_active      (win_active[c])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_pop = w_pop + 7'(fire_change[c]) + 7'(fire_timeout[c]);
    end

    // Accumulates the registered fires, hence one cycle behind them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_count <= '0;
        else       err_count <= CNT_W'(sat_add(32'(err_count), 32'(w_pop), CNT_W));
    end

`ifdef IVL_OVL_WIN_COVER_EN
    always_comb begin
        w_clean_pop = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_clean_pop = w_clean_pop + 7'(w_clean[c]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) win_count <= '0;
        else       win_count <= CNT_W'(sat_add(32'(win_count), 32'(w_clean_pop), CNT_W));
    end
`endif

endmodule

// File: tb/tb_ivl_ovl_win_unchange_multi.sv
// Directed bench: dut0 (no timeout), dut1 (MAX_WIN=4), dut2 (CNT_W=2, shares dut0 stimulus).
module tb_ivl_ovl_win_unchange_multi;

    logic        clock;
    logic        rst;
    logic        en0, en1;
    logic [3:0]  st0, ed0, st1, ed1;
    logic [15:0] ex0, ex1;
    logic [3:0]  fc0, ft0, wa0, fc1, ft1, wa1, fc2, ft2, wa2;
    logic [7:0]  ec0, ec1;
    logic [1:0]  ec2;
`ifdef IVL_OVL_WIN_COVER_EN
    logic [7:0]  wc0, wc1;
    logic [1:0]  wc2;
`endif
    int n_cmp, n_err;

    ivl_ovl_win_unchange_multi #(.NUM_CH(4), .WIDTH(4), .MAX_WIN(0), .CNT_W(8)) dut0 (
        .clock(clock), .reset(rst), .enable(en0), .start_event(st0), .end_event(ed0),
        .test_expr(ex0), .fire_change(fc0), .fire_timeout(ft0), .win_active(wa0),
`ifdef IVL_OVL_WIN_COVER_EN
        .win_count(wc0),
`endif
        .err_count(ec0));

    ivl_ovl_win_unchange_multi #(.NUM_CH(4), .WIDTH(4), .MAX_WIN(4), .CNT_W(8)) dut1 (
        .clock(clock), .reset(rst), .enable(en1), .start_event(st1), .end_event(ed1),
        .test_expr(ex1), .fire_change(fc1), .fire_timeout(ft1), .win_active(wa1),
`ifdef IVL_OVL_WIN_COVER_EN
        .win_count(wc1),
`endif
        .err_count(ec1));

    ivl_ovl_win_unchange_multi #(.NUM_CH(4), .WIDTH(4), .MAX_WIN(0), .CNT_W(2)) dut2 (
        .clock(clock), .reset(rst), .enable(en0), .start_event(st0), .end_event(ed0),
        .test_expr(ex0), .fire_change(fc2), .fire_timeout(ft2), .win_active(wa2),
`ifdef IVL_OVL_WIN_COVER_EN
        .win_count(wc2),
`endif
        .err_count(ec2));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst = 1'b1; en0 = 1'b1; en1 = 1'b1;
        st0 = '0; ed0 = '0; st1 = '0; ed1 = '0; ex0 = '0; ex1 = '0;
        tick(); tick();
        n_cmp++;
        if ({fc0, ft0, wa0, ec0} !== 20'd0) begin
            n_err++; $display("FAIL reset_dut0 got %h want 0", {fc0, ft0, wa0, ec0});
        end
        n_cmp++;
        if ({fc1, ft1, wa1, ec1, fc2, ft2, wa2, ec2} !== 34'd0) begin
            n_err++; $display("FAIL reset_dut12 got %h want 0", {fc1, ft1, wa1, ec1, fc2, ft2, wa2, ec2});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean();
        int act, fires;
        act = 0; fires = 0;
        ex0[3:0] = 4'b1100; st0[0] = 1'b1;
        tick();
        st0[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (wa0[0]) act++;
            if ((fc0 | ft0) != 4'd0) fires++;
            if (i == 5) ed0[0] = 1'b1;
            tick();
        end
        ed0[0] = 1'b0;
        n_cmp++;
        if (act !== 6) begin n_err++; $display("FAIL clean_active_cycles got %0d want 6", act); end
        n_cmp++;
        if (fires !== 0 || fc0 !== 4'd0) begin n_err++; $display("FAIL clean_fires got %0d want 0", fires); end
        n_cmp++;
        if (wa0[0] !== 1'b0) begin n_err++; $display("FAIL clean_closed got %b want 0", wa0[0]); end
        tick();
        n_cmp++;
        if (ec0 !== 8'd0) begin n_err++; $display("FAIL clean_err got %0d want 0", ec0); end
    endtask

    task automatic test_change();
        ex0[7:4] = 4'b0011; st0[1] = 1'b1;
        tick();
        st0[1] = 1'b0;
        tick();
        ex0[7:4] = 4'b0111;
        tick();
        n_cmp++;
        if (fc0 !== 4'b0010) begin n_err++; $display("FAIL change_first got %b want 0010", fc0); end
        ex0[7:4] = 4'b0011;
        tick();
        n_cmp++;
        if (fc0 !== 4'b0010) begin n_err++; $display("FAIL change_second got %b want 0010", fc0); end
        tick();
        n_cmp++;
        if (fc0 !== 4'b0000) begin n_err++; $display("FAIL change_pulse_end got %b want 0000", fc0); end
        n_cmp++;
        if (ec0 !== 8'd2 || ec2 !== 2'd2) begin
            n_err++; $display("FAIL change_err got %0d/%0d want 2/2", ec0, ec2);
        end
        ed0[1] = 1'b1;
        tick();
        ed0[1] = 1'b0;
        n_cmp++;
        if (wa0[1] !== 1'b0) begin n_err++; $display("FAIL change_close got %b want 0", wa0[1]); end
    endtask

    task automatic test_start_end();
        st0[0] = 1'b1; ed0[0] = 1'b1;
        tick();
        st0[0] = 1'b0; ed0[0] = 1'b0;
        n_cmp++;
        if (wa0[0] !== 1'b1) begin n_err++; $display("FAIL startend_open got %b want 1", wa0[0]); end
        tick();
        st0[0] = 1'b1;
        tick();
        st0[0] = 1'b0;
        n_cmp++;
        if (wa0[0] !== 1'b1) begin n_err++; $display("FAIL startend_restart got %b want 1", wa0[0]); end
        ed0[0] = 1'b1;
        tick();
        ed0[0] = 1'b0;
        n_cmp++;
        if (wa0[0] !== 1'b0 || fc0 !== 4'd0) begin
            n_err++; $display("FAIL startend_close got %b/%b want 0/0000", wa0[0], fc0);
        end
        tick();
        n_cmp++;
        if (ec0 !== 8'd2) begin n_err++; $display("FAIL startend_err got %0d want 2", ec0); end
    endtask

    task automatic test_timeout();
        st1[2] = 1'b1;
        tick();
        st1[2] = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            n_cmp++;
            if (wa1[2] !== 1'b1 || ft1 !== 4'd0) begin
                n_err++; $display("FAIL timeout_pre%0d got %b/%b want 1/0000", i, wa1[2], ft1);
            end
        end
        tick();
        n_cmp++;
        if (ft1 !== 4'b0100 || wa1[2] !== 1'b0) begin
            n_err++; $display("FAIL timeout_fire got %b/%b want 0100/0", ft1, wa1[2]);
        end
        tick();
        n_cmp++;
        if (ft1 !== 4'd0 || ec1 !== 8'd1) begin
            n_err++; $display("FAIL timeout_after got %b/%0d want 0000/1", ft1, ec1);
        end
        // End on the would-be timeout cycle: end wins.
        st1[2] = 1'b1;
        tick();
        st1[2] = 1'b0;
        tick(); tick(); tick();
        ed1[2] = 1'b1;
        tick();
        ed1[2] = 1'b0;
        n_cmp++;
        if (ft1 !== 4'd0 || wa1[2] !== 1'b0) begin
            n_err++; $display("FAIL timeout_endwins got %b/%b want 0000/0", ft1, wa1[2]);
        end
        tick();
        n_cmp++;
        if (ec1 !== 8'd1) begin n_err++; $display("FAIL timeout_endwins_err got %0d want 1", ec1); end
    endtask

    task automatic test_restart_ignored();
        st1[2] = 1'b1; ed1[2] = 1'b1;
        tick();
        st1[2] = 1'b0; ed1[2] = 1'b0;
        tick();
        st1[2] = 1'b1;
        tick();
        st1[2] = 1'b0;
        tick();
        n_cmp++;
        if (wa1[2] !== 1'b1 || ft1 !== 4'd0) begin
            n_err++; $display("FAIL restart_pre got %b/%b want 1/0000", wa1[2], ft1);
        end
        tick();
        n_cmp++;
        if (ft1 !== 4'b0100) begin n_err++; $display("FAIL restart_timeout got %b want 0100", ft1); end
        tick();
        n_cmp++;
        if (ec1 !== 8'd2) begin n_err++; $display("FAIL restart_err got %0d want 2", ec1); end
    endtask

    task automatic test_concurrent();
        ex0[3:0] = 4'b1010; ex0[15:12] = 4'b0101; st0 = 4'b1001;
        tick();
        st0 = 4'b0000;
        ex0[3:0] = 4'b1011; ex0[15:12] = 4'b0100;
        tick();
        n_cmp++;
        if (fc0 !== 4'b1001) begin n_err++; $display("FAIL concur_fire got %b want 1001", fc0); end
        tick();
        n_cmp++;
        if (ec0 !== 8'd4 || fc0 !== 4'd0) begin
            n_err++; $display("FAIL concur_err got %0d/%b want 4/0000", ec0, fc0);
        end
        n_cmp++;
        if (ec2 !== 2'd3) begin n_err++; $display("FAIL concur_sat got %0d want 3", ec2); end
        ex0[3:0] = 4'b0000;
        tick();
        n_cmp++;
        if (fc0 !== 4'b0001) begin n_err++; $display("FAIL concur_again got %b want 0001", fc0); end
        tick();
        n_cmp++;
        if (ec0 !== 8'd5 || ec2 !== 2'd3) begin
            n_err++; $display("FAIL concur_sat_hold got %0d/%0d want 5/3", ec0, ec2);
        end
`ifdef IVL_OVL_WIN_COVER_EN
        n_cmp++;
        if (wc0 !== 8'd2 || wc2 !== 2'd2 || wc1 !== 8'd1) begin
            n_err++; $display("FAIL cover_count got %0d/%0d/%0d want 2/1/2", wc0, wc1, wc2);
        end
`endif
    endtask

    task automatic test_reset_mid();
        n_cmp++;
        if (wa0 !== 4'b1001) begin n_err++; $display("FAIL rstmid_pre got %b want 1001", wa0); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({wa0, fc0, ec0, wa2, ec2} !== 22'd0) begin
            n_err++; $display("FAIL rstmid_async got %h want 0", {wa0, fc0, ec0, wa2, ec2});
        end
        @(negedge clock);
        rst = 1'b0;
        ex0[3:0] = 4'b1111; ex0[15:12] = 4'b1111;
        tick();
        n_cmp++;
        if ({wa0, fc0, ft0} !== 12'd0) begin
            n_err++; $display("FAIL rstmid_release got %h want 0", {wa0, fc0, ft0});
        end
        tick();
        n_cmp++;
        if (ec0 !== 8'd0) begin n_err++; $display("FAIL rstmid_err got %0d want 0", ec0); end
`ifdef IVL_OVL_WIN_COVER_EN
        n_cmp++;
        if (wc0 !== 8'd0) begin n_err++; $display("FAIL rstmid_cover got %0d want 0", wc0); end
`endif
    endtask

    task automatic test_enable_drop();
        ex0[7:4] = 4'b0011; st0[1] = 1'b1;
        tick();
        st0[1] = 1'b0;
        n_cmp++;
        if (wa0[1] !== 1'b1) begin n_err++; $display("FAIL endrop_open got %b want 1", wa0[1]); end
        en0 = 1'b0;
        tick();
        n_cmp++;
        if (wa0 !== 4'd0) begin n_err++; $display("FAIL endrop_idle got %b want 0000", wa0); end
        ex0[7:4] = 4'b1111;
        tick();
        en0 = 1'b1;
        tick();
        n_cmp++;
        if ({wa0, fc0, ft0} !== 12'd0) begin
            n_err++; $display("FAIL endrop_reen got %h want 0", {wa0, fc0, ft0});
        end
        tick();
        n_cmp++;
        if (ec0 !== 8'd0) begin n_err++; $display("FAIL endrop_err got %0d want 0", ec0); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        test_reset();
        test_clean();
        test_change();
        test_start_end();
        test_timeout();
        test_restart_ignored();
        test_concurrent();
        test_reset_mid();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
